inst_fetch_stage: RTL and testbench
===================================

Name: inst_fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the one-entry inter-stage data buffer (pipelined mode).
- Generates the PC and issues req/ack reads to instruction memory.
- Pushes {PC, instruction} into the buffer's write side (WInc/WData/WFull).
- Handles Jump redirects, including squashing an in-flight fetch.

Parameters:
AddrWidth, 64, PC / instruction-address width
InstWidth, 32, instruction word width
ResetPc, 64'h8000_0000, first fetch address after reset; bits [1:0] must be 0
PcStep, 4, PC increment per sequential fetch

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-low reset
JumpEn  input  1  redirect request from a later stage, single-cycle pulse
JumpAddr  input  AddrWidth  redirect target
IReq  output  1  instruction memory request, held until IAck
IAddr  output  AddrWidth  request address, stable while IReq=1
IAck  input  1  memory response valid; IRData valid the same cycle
IRData  input  InstWidth  fetched instruction
WData  output  AddrWidth+InstWidth  {Pc, Inst} to the buffer; matches buffer DataWidth
WInc  output  1  write strobe to the buffer
WFull  input  1  buffer full (buffer-side back-pressure)
IFault  output  1  sticky misaligned-jump flag; port exists only with FETCH_MISALIGN_CHECK_EN

Behaviour:
Reset (Rst=0, async) values:
- State=BOOT, Pc=ResetPc, HoldReg=0, DropPend=0.
- Outputs: IReq=0, IAddr=ResetPc, WInc=0, WData=0, IFault=0.

States:
- BOOT -> REQ, unconditionally, one cycle after reset release.
- REQ: IReq=1, IAddr=Pc.
  - IAck=0: stay in REQ.
  - IAck=1 and WFull=0: WInc=1 and WData={Pc,IRData} combinationally in the same cycle; Pc += PcStep; stay in REQ. This gives back-to-back fetch, 1 instruction/cycle with a 0-wait memory.
  - IAck=1 and WFull=1: HoldReg <= {Pc,IRData}; go to HOLD.
- HOLD: IReq=0; WData=HoldReg.
  - WInc = ~WFull.
  - On WInc: Pc += PcStep; go to REQ.
- DRAIN: IReq=1, IAddr unchanged. Used to keep the address stable after a jump arrives mid-request.
  - On IAck: discard IRData, WInc=0, Pc <= target, go to REQ.

Jump handling. JumpEn has priority over every other event in the same cycle.
- In REQ with IAck=0: the request is outstanding and must not change address. Latch JumpAddr into Target, set DropPend, go to DRAIN.
- In REQ with IAck=1: discard the response, WInc=0, Pc <= JumpAddr, stay in REQ.
- In HOLD: discard HoldReg, WInc=0, Pc <= JumpAddr, go to REQ.
- In DRAIN: overwrite Target with the newest JumpAddr (last jump wins).
- In BOOT: Pc <= JumpAddr.
- Never more than one memory request is outstanding.

Arithmetic and ordering:
- Pc increments modulo 2^AddrWidth; wrap from all-ones to 0 is silent.
- WData never carries a squashed instruction.
- WInc is never asserted while WFull=1.

Reset mid-operation: all state clears immediately; any outstanding IAck after reset release is ignored until BOOT completes.

Optional Feature:
Macro: FETCH_MISALIGN_CHECK_EN
- Defined:
  - JumpEn with JumpAddr[1:0]!=0 sets IFault (sticky until reset).
  - The stage goes to a FAULT state: IReq=0, WInc=0 until reset.
  - Later jumps are ignored.
- Undefined: JumpAddr[1:0] is forced to 0; no IFault port; no FAULT state.

Decomposition:
Shared package fetch_pkg contains:
- fetch_state_e enum {BOOT, REQ, HOLD, DRAIN, FAULT}
- typedef fetch_pkt_t struct {pc, inst}, the WData layout shared with the buffer instantiation
- localparam RESET_PC_DEFAULT

No sub-module. The PC/next-PC mux is inline; single flat module.

Test Plan:
1. Reset release, IAck tied high, WFull=0 -> IAddr 0x8000_0000, _04, _08 on consecutive cycles; WData={0x8000_0000,IRData} with WInc=1 one cycle after BOOT.
2. WFull=1 on IAck at Pc 0x8000_0008 for 3 cycles -> HOLD, IReq=0, WInc=0 for 3 cycles; then WInc=1 with the held packet; next IAddr 0x8000_000C.
3. JumpEn (target 0x8000_1000) while IReq pending, IAck delayed 4 cycles -> IAddr stays stable; the acked data is dropped (no WInc); next IAddr 0x8000_1000.
4. JumpEn coincident with IAck and WFull=0 -> WInc=0 that cycle; next IAddr = JumpAddr.
5. Two JumpEn pulses (0x100, then 0x200) during DRAIN -> the first fetch after drain is 0x200.
6. With FETCH_MISALIGN_CHECK_EN, JumpAddr 0x8000_0002 -> IFault=1 next cycle; IReq=0 and WInc=0 held until reset clears IFault.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage and the buffer it feeds.
package fetch_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  // WData layout; the buffer's DataWidth must equal ADDR_W+INST_W.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_fetch_stage.sv
// Instruction fetch: PC generation, req/ack memory reads, push into the one-entry buffer.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned jump raises sticky IFault and parks in FAULT.
module inst_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned          AddrWidth = ADDR_W,
  parameter int unsigned          InstWidth = INST_W,
  parameter logic [AddrWidth-1:0] ResetPc   = AddrWidth'(RESET_PC_DEFAULT),
  parameter int unsigned          PcStep    = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           JumpEn,
  input  logic [AddrWidth-1:0]           JumpAddr,
  output logic                           IReq,
  output logic [AddrWidth-1:0]           IAddr,
  input  logic                           IAck,
  input  logic [InstWidth-1:0]           IRData,
  output logic [AddrWidth+InstWidth-1:0] WData,
  output logic                           WInc,
  input  logic                           WFull
`ifdef FETCH_MISALIGN_CHECK_EN
  ,output logic                          IFault
`endif
);

  localparam int unsigned PktW = AddrWidth + InstWidth;

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] target_q, target_d;
  logic [PktW-1:0]      hold_q, hold_d;
  logic                 drop_q, drop_d;
  logic [AddrWidth-1:0] jaddr;
  logic [AddrWidth-1:0] pc_inc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misalign;
  assign jaddr    = JumpAddr;
  assign misalign = JumpEn && (JumpAddr[1:0] != 2'b00);
  assign IFault   = fault_q;
`else
  // Without the check, low address bits are simply dropped.
  assign jaddr = JumpAddr & ~AddrWidth'(3);
`endif

  assign pc_inc = pc_q + AddrWidth'(PcStep);
  assign IAddr  = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    hold_d   = hold_q;
    drop_d   = drop_q;
    IReq     = 1'b0;
    WInc     = 1'b0;
    WData    = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (JumpEn) pc_d = jaddr;
      end
      REQ: begin
        IReq = 1'b1;
        if (JumpEn) begin
          if (IAck) begin
            pc_d = jaddr;
          end else begin
            // Address must stay put until the outstanding request is acked.
            target_d = jaddr;
            drop_d   = 1'b1;
            state_d  = DRAIN;
          end
        end else if (IAck) begin
          if (!WFull) begin
            WInc  = 1'b1;
            WData = {pc_q, IRData};
            pc_d  = pc_inc;
          end else begin
            hold_d  = {pc_q, IRData};
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        WData = hold_q;
        if (JumpEn) begin
          pc_d    = jaddr;
          state_d = REQ;
        end else if (!WFull) begin
          WInc    = 1'b1;
          pc_d    = pc_inc;
          state_d = REQ;
        end
      end
      DRAIN: begin
        IReq = 1'b1;
        if (JumpEn) target_d = jaddr;
        if (IAck || !drop_q) begin
          drop_d  = 1'b0;
          pc_d    = JumpEn ? jaddr : target_q;
          state_d = REQ;
        end
      end
      FAULT: ;
      default: state_d = BOOT;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misalign && state_q != FAULT) begin
      fault_d = 1'b1;
      drop_d  = 1'b0;
      state_d = FAULT;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= BOOT;
      pc_q     <= ResetPc;
      target_q <= '0;
      hold_q   <= '0;
      drop_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios plus a randomized stream model.
module tb_inst_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;
  localparam logic [AW-1:0] RPC = 64'h8000_0000;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          JumpEn;
  logic [AW-1:0] JumpAddr;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IAck;
  logic [IW-1:0] IRData;
  logic [AW+IW-1:0] WData;
  logic          WInc;
  logic          WFull;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          IFault;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch_stage #(.AddrWidth(AW), .InstWidth(IW), .ResetPc(RPC), .PcStep(4)) dut (
    .Clk(Clk), .Rst(Rst), .JumpEn(JumpEn), .JumpAddr(JumpAddr),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData),
    .WData(WData), .WInc(WInc), .WFull(WFull)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,.IFault(IFault)
`endif
  );

  always #5 Clk = ~Clk;

  // Memory content is a fixed function of the address.
  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic fetch_pkt_t pkt_of(input logic [AW-1:0] a);
    fetch_pkt_t p;
    p.pc   = a;
    p.inst = inst_of(a);
    return p;
  endfunction

  assign IRData = inst_of(IAddr);

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Rst = 1'b0; JumpEn = 1'b0; JumpAddr = '0; IAck = 1'b0; WFull = 1'b0;
    tick; tick;
    Rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    Rst = 1'b0;
    #1;
    n_chk++; if (IReq !== 1'b0) begin n_fail++; $display("FAIL reset_ireq: got %b want 0", IReq); end
    n_chk++; if (IAddr !== RPC) begin n_fail++; $display("FAIL reset_iaddr: got %h want %h", IAddr, RPC); end
    n_chk++; if (WInc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b want 0", WInc); end
    n_chk++; if (WData !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WData); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_chk++; if (IFault !== 1'b0) begin n_fail++; $display("FAIL reset_ifault: got %b want 0", IFault); end
`endif
    Rst = 1'b1;
    IAck = 1'b1;
    #1;
    // BOOT ignores a stray ack.
    n_chk++; if (IReq !== 1'b0 || WInc !== 1'b0) begin n_fail++; $display("FAIL boot_ignore_ack: got ireq=%b winc=%b want 0/0", IReq, WInc); end
  endtask

  task automatic test_sequential;
    tick;
    for (int i = 0; i < 2; i++) begin
      logic [AW-1:0] a;
      a = RPC + AW'(4 * i);
      #1;
      n_chk++; if (IAddr !== a || IReq !== 1'b1) begin n_fail++; $display("FAIL seq_addr%0d: got %h/%b want %h/1", i, IAddr, IReq, a); end
      n_chk++; if (WInc !== 1'b1 || WData !== pkt_of(a)) begin n_fail++; $display("FAIL seq_push%0d: got %b %h want 1 %h", i, WInc, WData, pkt_of(a)); end
      tick;
    end
  endtask

  task automatic test_hold;
    logic [AW-1:0] a;
    a = RPC + 64'h8;
    WFull = 1'b1;
    #1;
    n_chk++; if (IAddr !== a || WInc !== 1'b0) begin n_fail++; $display("FAIL hold_entry: got %h/%b want %h/0", IAddr, WInc, a); end
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      n_chk++; if (IReq !== 1'b0 || WInc !== 1'b0) begin n_fail++; $display("FAIL hold_wait%0d: got ireq=%b winc=%b want 0/0", i, IReq, WInc); end
    end
    WFull = 1'b0;
    #1;
    n_chk++; if (WInc !== 1'b1 || WData !== pkt_of(a)) begin n_fail++; $display("FAIL hold_release: got %b %h want 1 %h", WInc, WData, pkt_of(a)); end
    tick;
    IAck = 1'b0;
    #1;
    n_chk++; if (IAddr !== RPC + 64'hC || IReq !== 1'b1 || WInc !== 1'b0) begin n_fail++; $display("FAIL hold_next: got %h/%b/%b want %h/1/0", IAddr, IReq, WInc, RPC + 64'hC); end
  endtask

  task automatic test_drain_jump;
    logic [AW-1:0] a;
    a = IAddr;
    JumpEn = 1'b1; JumpAddr = 64'h8000_1000;
    #1;
    n_chk++; if (WInc !== 1'b0) begin n_fail++; $display("FAIL drain_jump_winc: got %b want 0", WInc); end
    tick;
    JumpEn = 1'b0; JumpAddr = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (IAddr !== a || IReq !== 1'b1) begin n_fail++; $display("FAIL drain_stable%0d: got %h/%b want %h/1", i, IAddr, IReq, a); end
      tick;
    end
    IAck = 1'b1;
    #1;
    n_chk++; if (WInc !== 1'b0 || IAddr !== a) begin n_fail++; $display("FAIL drain_drop: got winc=%b addr=%h want 0 %h", WInc, IAddr, a); end
    tick; #1;
    n_chk++; if (IAddr !== 64'h8000_1000 || WInc !== 1'b1 || WData !== pkt_of(64'h8000_1000)) begin n_fail++; $display("FAIL drain_target: got %h %b %h want 8000_1000 1", IAddr, WInc, WData); end
  endtask

  task automatic test_jump_on_ack;
    tick;
    JumpEn = 1'b1; JumpAddr = 64'h8000_2000;
    #1;
    n_chk++; if (WInc !== 1'b0) begin n_fail++; $display("FAIL jack_squash: got %b want 0", WInc); end
    tick;
    JumpEn = 1'b0;
    #1;
    n_chk++; if (IAddr !== 64'h8000_2000 || WInc !== 1'b1) begin n_fail++; $display("FAIL jack_next: got %h/%b want 8000_2000/1", IAddr, WInc); end
  endtask

  task automatic test_double_jump;
    logic [AW-1:0] a;
    tick;
    a = IAddr;
    IAck = 1'b0; JumpEn = 1'b1; JumpAddr = 64'h100;
    #1;
    n_chk++; if (WInc !== 1'b0) begin n_fail++; $display("FAIL dj_first: got %b want 0", WInc); end
    tick;
    JumpAddr = 64'h200;
    #1;
    n_chk++; if (IAddr !== a || IReq !== 1'b1) begin n_fail++; $display("FAIL dj_stable: got %h/%b want %h/1", IAddr, IReq, a); end
    tick;
    JumpEn = 1'b0;
    tick;
    IAck = 1'b1;
    #1;
    n_chk++; if (WInc !== 1'b0) begin n_fail++; $display("FAIL dj_drop: got %b want 0", WInc); end
    tick; #1;
    n_chk++; if (IAddr !== 64'h200 || WInc !== 1'b1 || WData !== pkt_of(64'h200)) begin n_fail++; $display("FAIL dj_last_wins: got %h %b %h want 200 1", IAddr, WInc, WData); end
  endtask

  // Stream model: each delivered pc is the previous one plus 4, except that the
  // first delivery after a jump carries the latest jump target.
  task automatic test_random;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] prev_addr;
    logic          prev_req, prev_ack;
    int            n_deliv;
    do_reset;
    exp_pc = RPC; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; n_deliv = 0;
    for (int c = 0; c < 3000; c++) begin
      IAck   = ($urandom_range(0, 99) < 65);
      WFull  = ($urandom_range(0, 99) < 30);
      JumpEn = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       JumpAddr = 64'hFFFF_FFFF_FFFF_FFF4;
        1:       JumpAddr = {$urandom(), $urandom()};
        default: JumpAddr = 64'(RPC + 64'($urandom_range(0, 4095)));
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      JumpAddr[1:0] = 2'b00;
`endif
      #1;
      if (WInc) begin
        n_chk++; if (WFull) begin n_fail++; $display("FAIL rnd_winc_full: cycle %0d winc=1 while wfull=1", c); end
        n_chk++; if (JumpEn) begin n_fail++; $display("FAIL rnd_winc_jump: cycle %0d winc=1 with jump", c); end
        n_chk++; if (WData !== pkt_of(exp_pc)) begin n_fail++; $display("FAIL rnd_wdata: cycle %0d got %h want %h", c, WData, pkt_of(exp_pc)); end
        exp_pc = exp_pc + 64'd4;
        n_deliv++;
      end
      if (prev_req && !prev_ack) begin
        n_chk++; if (IReq !== 1'b1 || IAddr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_hold: cycle %0d got %b/%h want 1/%h", c, IReq, IAddr, prev_addr); end
      end
      if (JumpEn) exp_pc = JumpAddr & ~64'd3;
      prev_req = IReq; prev_ack = IAck; prev_addr = IAddr;
      tick;
    end
    JumpEn = 1'b0;
    n_chk++; if (n_deliv < 300) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 300", n_deliv); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_fault;
    do_reset;
    IAck = 1'b1;
    tick;
    JumpEn = 1'b1; JumpAddr = 64'h8000_0002;
    tick;
    JumpEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin JumpEn = 1'b1; JumpAddr = 64'h8000_0100; end
      else JumpEn = 1'b0;
      #1;
      n_chk++; if (IFault !== 1'b1 || IReq !== 1'b0 || WInc !== 1'b0) begin n_fail++; $display("FAIL fault_park%0d: got f=%b req=%b winc=%b want 1/0/0", i, IFault, IReq, WInc); end
      tick;
    end
    JumpEn = 1'b0;
    Rst = 1'b0;
    #1;
    n_chk++; if (IFault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b want 0", IFault); end
    tick;
    Rst = 1'b1;
  endtask
`endif

  initial begin
    Rst = 1'b0; JumpEn = 1'b0; JumpAddr = '0; IAck = 1'b0; WFull = 1'b0;
    test_reset;
    test_sequential;
    test_hold;
    test_drain_jump;
    test_jump_on_ack;
    test_double_jump;
    test_random;
`ifdef FETCH_MISALIGN_CHECK_EN
    test_fault;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
